fuzz_round_ctrl: RTL and testbench

//  Synthesizable sequencer for one differential-fuzzing round on the harness DUT.

---
 rtl/fuzz_round_ctrl_pkg.sv | 9 +
 rtl/fuzz_round_ctrl_if.sv | 23 ++
 rtl/fuzz_round_ctrl_stall_monitor.sv | 36 +++
 rtl/fuzz_round_ctrl.sv | 66 ++++++
 tb/tb_fuzz_round_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fuzz_round_ctrl_pkg.sv
// fuzz_round_ctrl_pkg: shared state, status and report types for the fuzzing round sequencer
package fuzz_round_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RST, RUN, REPORT} state_t;
    typedef enum logic [1:0] {ST_PASS = 2'd0, ST_TIMEOUT = 2'd1, ST_ABORT = 2'd2} status_t;
    typedef struct packed {
        status_t     status;
        logic [63:0] cycles;
    } rpt_t;
endpackage

// File: rtl/fuzz_round_ctrl_if.sv
// fuzz_round_ctrl_if: host/harness bundle between the test host and the round sequencer
interface fuzz_round_ctrl_if #(parameter int COV_W = 30);
    logic             tc_valid;
    logic             tc_ready;
    logic             abort;
    logic [63:0]      tohost;
    logic [COV_W-1:0] cov;
    logic             dut_reset;
    logic             stall_irq;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [1:0]       rpt_status;
    logic [63:0]      rpt_cycles;
    logic [COV_W-1:0] rpt_cov;
    modport master (
        output tc_valid, abort, tohost, cov, rpt_ready,
        input  tc_ready, dut_reset, stall_irq, rpt_valid, rpt_status, rpt_cycles, rpt_cov
    );
    modport slave (
        input  tc_valid, abort, tohost, cov, rpt_ready,
        output tc_ready, dut_reset, stall_irq, rpt_valid, rpt_status, rpt_cycles, rpt_cov
    );
endinterface

// File: rtl/fuzz_round_ctrl_stall_monitor.sv
// fuzz_round_ctrl_stall_monitor: coverage-stall and watchdog counters driving a registered interrupt
module fuzz_round_ctrl_stall_monitor #(
    parameter int COV_W      = 30,
    parameter int MAX_WAIT   = 1000,
    parameter int COV_SHIFT  = 19,
    parameter int WDOG_LIMIT = 50000
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [COV_W-1:0] cov,
    input  logic             tohost0,
    output logic             stall_irq
);
    logic [COV_W-1:0] pre_cov;
    logic [63:0]      stall_cnt, wdog_cnt, stall_nxt, wdog_nxt, thr;
    // higher coverage earns a proportionally longer stall window
    always_comb begin
        thr       = 64'(MAX_WAIT) * (64'(cov >> COV_SHIFT) + 64'd1);
        stall_nxt = cov != pre_cov ? '0 : &stall_cnt ? stall_cnt : stall_cnt + 64'd1;
        wdog_nxt  = tohost0 ? '0 : &wdog_cnt ? wdog_cnt : wdog_cnt + 64'd1;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            pre_cov   <= '0;
            stall_cnt <= '0;
            wdog_cnt  <= '0;
            stall_irq <= 1'b0;
        end else if (en) begin
            pre_cov   <= cov;
            stall_cnt <= stall_nxt;
            wdog_cnt  <= wdog_nxt;
            stall_irq <= stall_nxt >= thr || wdog_nxt >= 64'(WDOG_LIMIT);
        end
    end
endmodule

// File: rtl/fuzz_round_ctrl.sv
// fuzz_round_ctrl: sequences one fuzzing round (handshake, DUT reset, run, report)
module fuzz_round_ctrl import fuzz_round_ctrl_pkg::*; #(
    parameter int COV_W      = 30,
    parameter int RST_CYCLES = 8,
    parameter int MAX_CYCLES = 200000,
    parameter int MAX_WAIT   = 1000,
    parameter int COV_SHIFT  = 19,
    parameter int WDOG_LIMIT = 50000
) (
    input logic               clock,
    input logic               reset,
    fuzz_round_ctrl_if.slave  bus
);
    state_t           state, state_nxt;
    status_t          status;
    rpt_t             rpt;
    logic [COV_W-1:0] rpt_cov;
    logic [31:0]      rst_cnt;
    logic [63:0]      cyc_cnt, run_cnt;
    logic             done;
    // run_cnt is the count including the current cycle, which is what gets reported
    always_comb begin
        run_cnt   = &cyc_cnt ? cyc_cnt : cyc_cnt + 64'd1;
        status    = bus.tohost[0] ? ST_PASS : bus.abort ? ST_ABORT : ST_TIMEOUT;
        done      = bus.tohost[0] || bus.abort || run_cnt >= 64'(MAX_CYCLES);
        state_nxt = state == IDLE && bus.tc_valid ? RST
                  : state == RST && rst_cnt == '0 ? RUN
                  : state == RUN && done ? REPORT
                  : state == REPORT && bus.rpt_ready ? IDLE
                  : state;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            rst_cnt <= '0;
            cyc_cnt <= '0;
            rpt     <= '0;
            rpt_cov <= '0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= state == IDLE ? 32'(RST_CYCLES - 1) : state == RST && rst_cnt != '0 ? rst_cnt - 32'd1 : rst_cnt;
            cyc_cnt <= state == RUN ? run_cnt : '0;
            if (state == RUN && done) begin
                rpt     <= '{status: status, cycles: run_cnt};
                rpt_cov <= bus.cov;
            end
        end
    end
    assign bus.tc_ready   = state == IDLE;
    assign bus.dut_reset  = state != RUN;
    assign bus.rpt_valid  = state == REPORT;
    assign bus.rpt_status = rpt.status;
    assign bus.rpt_cycles = rpt.cycles;
    assign bus.rpt_cov    = rpt_cov;
    // monitor state is zeroed whenever the next cycle is not a run cycle
    fuzz_round_ctrl_stall_monitor #(
        .COV_W(COV_W), .MAX_WAIT(MAX_WAIT), .COV_SHIFT(COV_SHIFT), .WDOG_LIMIT(WDOG_LIMIT)
    ) mon (
        .clock    (clock),
        .clear    (!reset || state_nxt != RUN),
        .en       (state == RUN),
        .cov      (bus.cov),
        .tohost0  (bus.tohost[0]),
        .stall_irq(bus.stall_irq)
    );
endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// tb_fuzz_round_ctrl: table-driven and randomized rounds against a cycle-index reference model
module tb_fuzz_round_ctrl;
    localparam int MAXC = 3000;
    localparam int WDOG = 2500;
    localparam int RSTC = 8;
    localparam int AN   = MAXC + 8;

    typedef struct {
        string name;
        int    th_k;
        int    ab_k;
        bit    cconst;
        int    cval;
        int    e_st;
        int    e_cyc;
        int    e_cov;
        int    e_irq;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit          th_a [AN];
    bit          ab_a [AN];
    logic [29:0] cv_a [AN];
    bit          irq_e[AN];
    vec_t        tbl[8];

    fuzz_round_ctrl_if #(.COV_W(30)) bus();

    fuzz_round_ctrl #(
        .COV_W(30), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .MAX_WAIT(1000), .COV_SHIFT(19), .WDOG_LIMIT(WDOG)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic gen_vec(input vec_t v);
        for (int k = 0; k < AN; k++) begin
            th_a[k] = k > 0 && k == v.th_k;
            ab_a[k] = k > 0 && k == v.ab_k;
            cv_a[k] = k == 0 ? 30'd0 : v.cconst ? 30'(v.cval) : 30'(k);
        end
    endtask

    task automatic gen_rand();
        int mode, pm, pos;
        logic [29:0] val;
        int pms[3] = '{0, 1, 40};
        mode = int'($urandom_range(0, 3));
        pm   = pms[$urandom_range(0, 2)];
        pos  = int'($urandom_range(1, 2600));
        val  = '0;
        cv_a[0] = '0;
        for (int k = 0; k < AN; k++) begin
            th_a[k] = 1'b0;
            ab_a[k] = 1'b0;
        end
        for (int k = 1; k < AN; k++) begin
            if (int'($urandom_range(0, 999)) < pm) val = 30'($urandom_range(0, 2097151));
            cv_a[k] = val;
        end
        if (mode == 1 || mode == 3) th_a[pos] = 1'b1;
        if (mode == 2) ab_a[pos] = 1'b1;
        if (mode == 3) ab_a[$urandom_range(1, 2600)] = 1'b1;
    endtask

    // exit is the first cycle with a finish or abort (or the budget); irq reflects
    // the stall length and run length as of the previous cycle
    task automatic model(output int e, output int st);
        int last;
        e = MAXC;
        for (int k = 1; k <= MAXC; k++)
            if (th_a[k] || ab_a[k]) begin
                e = k;
                break;
            end
        st = th_a[e] ? 0 : ab_a[e] ? 2 : 1;
        last = 0;
        irq_e[1] = 1'b0;
        for (int k = 2; k <= e; k++) begin
            if (cv_a[k-1] != cv_a[k-2]) last = k - 1;
            irq_e[k] = (k - 1 - last) >= 1000 * (int'(cv_a[k-1] >> 19) + 1) || (k - 1) >= WDOG;
        end
    endtask

    task automatic start_round();
        int n;
        n = 0;
        while (!bus.tc_ready && n < 20) begin
            step();
            n++;
        end
        chk("tc_ready_wait", bus.tc_ready, 1);
        bus.tc_valid = 1'b1;
        step();
        bus.tc_valid = 1'b0;
        n = 0;
        while (bus.dut_reset && n < 100) begin
            n++;
            step();
        end
        chk("rst_window", n, RSTC);
    endtask

    task automatic do_round(output int e, output int st, output int irq_first);
        int k, diffs;
        model(e, st);
        start_round();
        k = 1;
        diffs = 0;
        irq_first = 0;
        while (!bus.dut_reset && k <= MAXC + 5) begin
            if (bus.stall_irq !== irq_e[k]) diffs++;
            if (bus.stall_irq && irq_first == 0) irq_first = k;
            bus.cov    = cv_a[k];
            bus.abort  = ab_a[k];
            bus.tohost = {$urandom(), 31'($urandom()), th_a[k]};
            step();
            k++;
        end
        bus.abort  = 1'b0;
        bus.tohost = '0;
        chk("run_len", k - 1, e);
        chk("irq_trace_diffs", diffs, 0);
        chk("rpt_valid", bus.rpt_valid, 1);
        chk("rpt_status", bus.rpt_status, st);
        chk("rpt_cycles", bus.rpt_cycles, e);
        chk("rpt_cov", bus.rpt_cov, cv_a[e]);
    endtask

    task automatic ack();
        bus.rpt_ready = 1'b1;
        step();
        bus.rpt_ready = 1'b0;
        chk("ack_rpt_valid", bus.rpt_valid, 0);
        chk("ack_tc_ready", bus.tc_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at time %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int e, st, irqf, bad;
        vec_t h;
        bus.tc_valid  = 1'b0;
        bus.abort     = 1'b0;
        bus.tohost    = '0;
        bus.cov       = '0;
        bus.rpt_ready = 1'b0;
        tbl[0] = '{"pass500",    500,  0,  0, 0,       0, 500,  500,    0};
        tbl[1] = '{"timeout",    0,    0,  0, 0,       1, 3000, 3000,   2501};
        tbl[2] = '{"pass_max",   3000, 0,  0, 0,       0, 3000, 3000,   2501};
        tbl[3] = '{"stall_c3",   1100, 0,  1, 3,       0, 1100, 3,      1002};
        tbl[4] = '{"stall_big",  2100, 0,  1, 524288,  0, 2100, 524288, 2002};
        tbl[5] = '{"abort10",    0,    10, 0, 0,       2, 10,   10,     0};
        tbl[6] = '{"abort_pass", 10,   10, 0, 0,       0, 10,   10,     0};
        tbl[7] = '{"abort1",     0,    1,  1, 7,       2, 1,    7,      0};
        repeat (3) step();
        chk("reset_tc_ready", bus.tc_ready, 1);
        chk("reset_dut_reset", bus.dut_reset, 1);
        chk("reset_rpt_valid", bus.rpt_valid, 0);
        chk("reset_stall_irq", bus.stall_irq, 0);
        reset = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            gen_vec(tbl[i]);
            do_round(e, st, irqf);
            chk({tbl[i].name, "_status"}, bus.rpt_status, tbl[i].e_st);
            chk({tbl[i].name, "_cycles"}, bus.rpt_cycles, tbl[i].e_cyc);
            chk({tbl[i].name, "_cov"}, bus.rpt_cov, tbl[i].e_cov);
            chk({tbl[i].name, "_irq_first"}, irqf, tbl[i].e_irq);
            ack();
        end
        h = '{"hold", 0, 5, 0, 0, 2, 5, 5, 0};
        gen_vec(h);
        do_round(e, st, irqf);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            bus.tc_valid = j[0];
            if (bus.rpt_valid !== 1'b1 || bus.tc_ready !== 1'b0 || bus.rpt_status !== 2'd2 ||
                bus.rpt_cycles !== 64'd5 || bus.rpt_cov !== 30'd5) bad++;
            step();
        end
        bus.tc_valid = 1'b0;
        chk("hold_unstable_cycles", bad, 0);
        ack();
        repeat (3) step();
        chk("idle_after_hold", bus.tc_ready, 1);
        for (int r = 0; r < 8; r++) begin
            gen_rand();
            do_round(e, st, irqf);
            ack();
        end
        bus.cov = '0;
        start_round();
        repeat (1005) step();
        chk("pre_reset_irq", bus.stall_irq, 1);
        chk("pre_reset_dut_reset", bus.dut_reset, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_tc_ready", bus.tc_ready, 1);
        chk("midrst_dut_reset", bus.dut_reset, 1);
        chk("midrst_rpt_valid", bus.rpt_valid, 0);
        chk("midrst_stall_irq", bus.stall_irq, 0);
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            step();
            if (bus.rpt_valid !== 1'b0 || bus.tc_ready !== 1'b1) bad++;
        end
        chk("midrst_quiet_cycles", bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
